// File: rtl/display_pkg.sv
// Shared types and constants for the binary-to-BCD display update path.
// The HOLD state exists only when HOLD_TIMER_EN is defined.
package display_pkg;

    // Largest value the 4-digit display can show; larger inputs saturate to it.
    localparam int unsigned BCD_MAX    = 9999;
    // Width of one BCD digit.
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 4;
    // Width of the BCD accumulator (four digits).
    localparam int unsigned BCD_W      = DIGIT_W * NUM_DIGITS;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        PUBLISH = 2'd2
`ifdef HOLD_TIMER_EN
        ,
        HOLD    = 2'd3
`endif
    } state_e;

    // Published digits, most significant first so the packed layout matches
    // the BCD accumulator bit for bit.
    typedef struct packed {
        logic [DIGIT_W-1:0] thousands;
        logic [DIGIT_W-1:0] hundreds;
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] ones;
    } digits_t;

endpackage : display_pkg

// File: rtl/bcd_add3.sv
// One double-dabble correction step: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next digit.
module bcd_add3
    import display_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);

    // Add 3 when the digit would reach 10 or more after doubling.
    always_comb begin
        digit_out = (digit_in >= DIGIT_W'(5)) ? digit_in + DIGIT_W'(3) : digit_in;
    end

endmodule : bcd_add3

// File: rtl/bcd_update_ctrl.sv
// Binary-to-BCD display update controller.
// Accepts a binary value in IDLE, saturates it to 9999, converts it with a
// shift-add-3 sequence (one bit per clock), then publishes four BCD digits
// with a one-cycle done pulse. Fixed latency: WIDTH+1 clocks from transfer.
// Optional feature: define HOLD_TIMER_EN to add a HOLD state that blocks new
// transfers for HOLD_CYCLES clocks (minimum one) after each publish.
module bcd_update_ctrl
    import display_pkg::*;
#(
    parameter int WIDTH       = 14,
    parameter int HOLD_CYCLES = 5000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_value,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DIGIT_W-1:0] ones,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] hundreds,
    output logic [DIGIT_W-1:0] thousands,
    output logic               ovf,
    output logic               done,
    output logic               busy
);

    // The shift path slices the binary register, so it needs at least 2 bits.
    if (WIDTH < 2 || HOLD_CYCLES < 0) begin : g_param_check
        $error("bcd_update_ctrl: WIDTH must be >= 2 and HOLD_CYCLES >= 0");
    end

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               ovf_pending_q, ovf_pending_d;
    digits_t            disp_q, disp_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic               in_over;
    logic [WIDTH-1:0]   in_sat;

`ifdef HOLD_TIMER_EN
    // A zero hold still spends one cycle in HOLD.
    localparam int HOLD_EFF = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
    localparam int HOLD_W   = (HOLD_EFF > 1) ? $clog2(HOLD_EFF) : 1;

    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
`endif

    // Per-digit correction of the accumulator ahead of each shift.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_in  (bcd_q[g*DIGIT_W +: DIGIT_W]),
            .digit_out (bcd_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Saturate the incoming value to what four digits can show.
    always_comb begin
        in_over = (32'(in_value) > BCD_MAX);
        in_sat  = in_over ? WIDTH'(BCD_MAX) : in_value;
    end

    // Next-state, datapath and output-register logic.
    always_comb begin
        // NOTE: every signal gets its hold value first; a path that skips an
        // assignment would otherwise infer a latch.
        state_d       = state_q;
        bin_d         = bin_q;
        bcd_d         = bcd_q;
        bit_cnt_d     = bit_cnt_q;
        ovf_pending_d = ovf_pending_q;
        disp_d        = disp_q;
        ovf_d         = ovf_q;
        done_d        = 1'b0;
`ifdef HOLD_TIMER_EN
        hold_cnt_d    = hold_cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    bin_d         = in_sat;
                    bcd_d         = '0;
                    bit_cnt_d     = '0;
                    ovf_pending_d = in_over;
                    state_d       = CONVERT;
                end
            end

            CONVERT: begin
                // Correct every digit, then shift the next binary bit in.
                bcd_d     = {bcd_adj[BCD_W-2:0], bin_q[WIDTH-1]};
                bin_d     = bin_q << 1;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = PUBLISH;
                end
            end

            PUBLISH: begin
                disp_d = digits_t'(bcd_q);
                ovf_d  = ovf_pending_q;
                done_d = 1'b1;
`ifdef HOLD_TIMER_EN
                hold_cnt_d = '0;
                state_d    = HOLD;
`else
                state_d    = IDLE;
`endif
            end

`ifdef HOLD_TIMER_EN
            HOLD: begin
                if (hold_cnt_q == HOLD_W'(HOLD_EFF - 1)) begin
                    hold_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the shift registers are reset along with the control state so
        // a reset mid-conversion leaves nothing behind to leak into a publish.
        if (rst) begin
            state_q       <= IDLE;
            bin_q         <= '0;
            bcd_q         <= '0;
            bit_cnt_q     <= '0;
            ovf_pending_q <= 1'b0;
            disp_q        <= '0;
            ovf_q         <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            state_q       <= state_d;
            bin_q         <= bin_d;
            bcd_q         <= bcd_d;
            bit_cnt_q     <= bit_cnt_d;
            ovf_pending_q <= ovf_pending_d;
            disp_q        <= disp_d;
            ovf_q         <= ovf_d;
            done_q        <= done_d;
        end
    end

`ifdef HOLD_TIMER_EN
    // Hold-off counter between publishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`endif

    // Output mapping.
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        ones      = disp_q.ones;
        tens      = disp_q.tens;
        hundreds  = disp_q.hundreds;
        thousands = disp_q.thousands;
        ovf       = ovf_q;
        done      = done_q;
    end

endmodule : bcd_update_ctrl

// File: tb/tb_bcd_update_ctrl.sv
// Scoreboard bench for bcd_update_ctrl (WIDTH=14, HOLD_CYCLES=8).
// The driver predicts acceptance from the transfer/latency rules and pushes
// the expected publish; the monitor pops on every done pulse.
module tb_bcd_update_ctrl;

    localparam int WIDTH   = 14;
    localparam int HOLD    = 8;
    localparam int LATENCY = WIDTH + 1;
`ifdef HOLD_TIMER_EN
    localparam int GAP = LATENCY + 1 + HOLD;
`else
    localparam int GAP = LATENCY + 1;
`endif

    typedef struct {
        logic [16:0] val;     // {thousands, hundreds, tens, ones, ovf}
        int          edge_n;  // clock edge on which the transfer happened
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_value = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       ones, tens, hundreds, thousands;
    logic             ovf, done, busy;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   next_ok = 0;
    exp_t sb_q[$];
    logic [16:0] last_pub = '0;
    logic        prev_done = 1'b0;

    bcd_update_ctrl #(.WIDTH(WIDTH), .HOLD_CYCLES(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_value  (in_value),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ones      (ones),
        .tens      (tens),
        .hundreds  (hundreds),
        .thousands (thousands),
        .ovf       (ovf),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: saturate, then split into decimal digits with plain arithmetic.
    function automatic logic [16:0] model(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10), 1'(v > 9999)};
    endfunction

    // One clock of stimulus, called at a negative edge.
    task automatic drive_cycle(input logic valid, input int value);
        int   e;
        logic exp_rdy;
        exp_t x;
        in_valid = valid;
        in_value = WIDTH'(value);
        e = cyc + 1;
        exp_rdy = (e >= next_ok);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (valid && exp_rdy) begin
            x.val    = model(value);
            x.edge_n = e;
            sb_q.push_back(x);
            next_ok = e + GAP;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, int'($urandom_range(0, 16383)));
    endtask

    // Wait (bounded) until the model says a transfer is possible, then send.
    task automatic send(input int value);
        int guard = 0;
        while (cyc + 1 < next_ok && guard < 200) begin
            drive_cycle(1'b0, int'($urandom_range(0, 16383)));
            guard++;
        end
        if (guard >= 200) check("send_timeout", 32'(guard), 32'(0));
        drive_cycle(1'b1, value);
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digits"}, 32'({thousands, hundreds, tens, ones}), 32'(0));
        check({tag, "_ovf"},    32'(ovf),  32'(0));
        check({tag, "_done"},   32'(done), 32'(0));
        check({tag, "_busy"},   32'(busy), 32'(0));
    endtask

    // Monitor: compare each publish against the scoreboard; between publishes
    // the digits must hold the last published value.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_done = 1'b0;
            end else begin
                if (done) begin
                    if (prev_done) check("done_width", 32'(1), 32'(0));
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 32'(1), 32'(0));
                    end else begin
                        x = sb_q.pop_front();
                        check("publish", 32'({thousands, hundreds, tens, ones, ovf}), 32'(x.val));
                        check("latency", 32'(cyc - x.edge_n), 32'(LATENCY));
                        last_pub = x.val;
                    end
                end else begin
                    check("digits_hold", 32'({thousands, hundreds, tens, ones, ovf}), 32'(last_pub));
                end
                prev_done = done;
            end
        end
    end

    initial begin
        // Power-on reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        next_ok = cyc + 1;
        check("ready_after_por", 32'(in_ready), 32'(1));

        // Directed values, including saturation and recovery.
        send(1234);
        send(0);
        send(9999);
        send(16383);
        send(42);
        idle(GAP);

        // Reset five cycles into the conversion of 5678.
        send(5678);
        idle(4);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        sb_q.delete();
        last_pub = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        next_ok = cyc + 1;
        check("ready_after_rst", 32'(in_ready), 32'(1));
        idle(2 * GAP);

        // in_valid held high with a changing value.
        for (int i = 0; i < 3 * GAP; i++) drive_cycle(1'b1, int'($urandom_range(0, 16383)));
        in_valid = 1'b0;

        // Random traffic with random valid gaps.
        for (int i = 0; i < 400; i++) begin
            drive_cycle(($urandom_range(0, 3) == 0), int'($urandom_range(0, 16383)));
        end
        in_valid = 1'b0;

        // Drain.
        idle(2 * GAP);
        check("scoreboard_empty", 32'(sb_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_bcd_update_ctrl

// File: doc/bcd_update_ctrl.md
BCD_UPDATE_CTRL -- requirements
Module: bcd_update_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 14, binary input width (max value 16383).
REQ-002 SHALL have parameter HOLD_CYCLES, default 5000000, minimum clk cycles between published updates (0.1 s at 50 MHz); used only with HOLD_TIMER_EN.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_value  input  WIDTH  binary value to display.
REQ-006 SHALL have port in_valid  input  1  in_value is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts in_value this cycle.
REQ-008 SHALL have ports ones, tens, hundreds, thousands  output  4 each  BCD digits (0..9) for the 4-digit display driver.
REQ-009 SHALL have port ovf  output  1  published value was saturated.
REQ-010 SHALL have port done  output  1  one-cycle pulse when new digits are published.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, CONVERT, PUBLISH, HOLD.
REQ-013 SHALL assert in_ready only in IDLE; transfer occurs when in_valid && in_ready on a rising edge.
REQ-014 SHALL, on transfer, load min(in_value, 9999) into the shift register, set internal ovf_pending = (in_value > 9999), and go to CONVERT.
REQ-015 SHALL convert by shift-add-3 (double dabble), one bit per cycle, exactly WIDTH cycles in CONVERT, using a 16-bit internal BCD accumulator.
REQ-016 SHALL, after the last shift, enter PUBLISH for one cycle, register the four digits and ovf from the accumulator, and pulse done.
REQ-017 SHALL give a fixed latency: digits and done valid WIDTH+1 cycles after the transfer edge (15 for WIDTH=14).
REQ-018 SHALL change ones/tens/hundreds/thousands/ovf only on the PUBLISH cycle; they hold their values in all other cycles.
REQ-019 SHALL ignore in_valid while not in IDLE; no queuing; a dropped request has no side effects.
REQ-020 SHALL leave PUBLISH for HOLD (HOLD_TIMER_EN defined) or IDLE (undefined).
REQ-021 SHALL never output a digit above 9 in any state.

Reset
REQ-022 SHALL, on rst asserted at any time (including mid-CONVERT or HOLD), immediately force state IDLE, digits 0000, ovf 0, done 0, busy 0, hold counter 0, and abandon any conversion in progress.
REQ-023 SHALL assert in_ready on the first clk edge after rst deasserts.

Configuration
REQ-024 SHALL use macro HOLD_TIMER_EN: when defined, HOLD counts HOLD_CYCLES cycles after PUBLISH, then returns to IDLE; in_ready stays low during HOLD.
REQ-025 SHALL, without HOLD_TIMER_EN, compile out the HOLD state and counter; the next transfer is possible on the cycle after PUBLISH.
REQ-026 SHALL treat HOLD_CYCLES = 0 with HOLD_TIMER_EN as a single HOLD cycle.

Structure
REQ-027 SHALL place the FSM state enum, the BCD_MAX (9999) constant and the digit-width constant (4) in shared package display_pkg.
REQ-028 SHALL keep the shift-add-3 step (one 4-bit digit correction: +3 when >= 5) as sub-module bcd_add3, instantiated once per digit.
REQ-029 SHALL add no further sub-modules; the FSM, counters and output registers reside in bcd_update_ctrl.

Verification
REQ-030 SHALL cover: in_value=1234 transferred -> after 15 cycles thousands..ones = 1,2,3,4; ovf 0; done pulses for exactly 1 cycle.
REQ-031 SHALL cover: in_value=0 -> digits 0000; in_value=9999 -> 9999 with ovf 0.
REQ-032 SHALL cover: in_value=16383 -> digits 9999 with ovf 1; next in_value=42 -> 0042 with ovf 0.
REQ-033 SHALL cover: rst pulsed 5 cycles into CONVERT of 5678 -> digits 0000, no done pulse, in_ready high after rst release.
REQ-034 SHALL cover: in_valid held high with a changing value during CONVERT -> value sampled only at the transfer edge; digits unchanged until PUBLISH.
REQ-035 SHALL cover: with HOLD_TIMER_EN and HOLD_CYCLES=8 -> second transfer no earlier than 8 cycles after done; without the macro -> transfer accepted on the cycle after done.
